instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  RESET_PC 32'h0000_0000 PC value after reset
  INSTR_BASE 32'h0000_0000 lowest legal fetch address
  INSTR_LIMIT 32'h0001_0000 first illegal fetch address (exclusive)
REQ-002 Ports (name direction width meaning) SHALL be:
  clk input 1 single clock, all state on posedge
  reset_n input 1 synchronous, active-high reset (asserted = 1), despite the name
  pc_inc input 1 consumer accepts current instruction; advance PC by 4
  pc_load input 1 redirect fetch to pc_target
  pc_target input 32 redirect address
  mem_ack input 1 memory returns read data this cycle
  mem_err input 1 memory bus error, qualified by mem_ack
  mem_rdata input 32 read data, qualified by mem_ack
  mem_req output 1 read request, held until mem_ack
  mem_addr output 32 read address, stable while mem_req=1
  instruction output 32 fetched instruction word
  wait_instr output 1 instruction not yet valid
  instr_segv output 1 fetch fault
  pc output 32 address of the word held in instruction

Function
REQ-003 The FSM SHALL have states FETCH, VALID and FAULT, encoded in 2 bits.
REQ-004 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal pc; in VALID and FAULT, mem_req SHALL be 0.
REQ-005 A fetch SHALL be legal only if pc[1:0]==0 and INSTR_BASE <= pc < INSTR_LIMIT.
REQ-006 On entry to FETCH with an illegal pc, the block SHALL go to FAULT on the next edge without asserting mem_req.
REQ-007 In FETCH, mem_ack with mem_err=0 and no pending redirect SHALL latch mem_rdata into instruction and move to VALID on the same edge.
REQ-008 In FETCH, mem_ack with mem_err=1 SHALL move to FAULT, and instruction SHALL stay unchanged.
REQ-009 pc_load in FETCH SHALL set a 1-bit redirect_pending flag and store pc_target.
  - mem_addr SHALL stay unchanged until mem_ack.
  - On mem_ack the returned data SHALL be discarded, pc SHALL take the stored target, the flag SHALL clear, and the block SHALL stay in FETCH.
REQ-010 pc_load in VALID or FAULT SHALL load pc with pc_target and enter FETCH on the next edge.
REQ-011 pc_inc in VALID without pc_load SHALL set pc to pc+4 (modulo 2^32) and enter FETCH.
  - pc_inc in FETCH or FAULT SHALL be ignored.
REQ-012 pc_load SHALL take priority over pc_inc in the same cycle.
REQ-013 A later pc_load while redirect_pending is set SHALL overwrite the stored target (last wins).
REQ-014 wait_instr SHALL be 1 exactly when the state is FETCH.
REQ-015 instr_segv SHALL be 1 exactly when the state is FAULT.
REQ-016 FAULT SHALL be left only by pc_load or by reset.
REQ-017 Latency SHALL be at minimum one cycle from mem_req first asserted to VALID (mem_ack in the same cycle as the request).
REQ-018 pc wrap from 32'hFFFF_FFFC SHALL produce 0, which is then range-checked normally.

Reset
REQ-019 While reset_n=1 at a posedge, the block SHALL set:
  - state=FETCH
  - pc=RESET_PC
  - instruction=0
  - redirect_pending=0
REQ-020 Reset asserted mid-request SHALL abandon the request.
  - A mem_ack arriving in the first cycle after reset SHALL be treated as the response to a new fetch of RESET_PC.
  - The memory side SHALL therefore drop outstanding reads on reset.
REQ-021 Outputs SHALL be registered or derived only from state, pc and instruction; there SHALL be no combinational path from mem_rdata to instruction.

Structure
REQ-022 The state encodings and the instruction width (32) SHALL live in a shared package that control-path blocks also use.
REQ-023 The range/alignment check SHALL be one sub-module, fetch_addr_check: input addr, output legal, purely combinational, reusable for data-side segv.
REQ-024 The block SHALL contain no memory; it SHALL hold a single instruction buffer.

Verification
REQ-025 Reset, then mem_ack=1 with mem_rdata=32'h8000_1234 on the first request -> instruction=32'h8000_1234, wait_instr=0, pc=0 the next cycle.
REQ-026 In VALID at pc=0x10, pulse pc_inc -> mem_addr=0x14 and wait_instr=1 the next cycle.
REQ-027 pc_inc and pc_load(target 0x40) asserted together in VALID -> mem_addr=0x40, not pc+4.
REQ-028 pc_load(0x80) during FETCH at 0x20, then mem_ack with data 0xDEAD_BEEF -> data discarded, next mem_addr=0x80, instruction unchanged.
REQ-029 Fault cases:
  - pc_load(0x0001_0000) -> instr_segv=1 with no mem_req.
  - pc_load(0x6) -> instr_segv=1.
  - mem_ack with mem_err=1 -> instr_segv=1.
  - pc_load(0x8) from FAULT -> the block recovers.
REQ-030 Assert reset_n while a request is outstanding -> pc=RESET_PC, redirect_pending=0, mem_addr=RESET_PC the next cycle.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Definitions shared by the instruction fetch unit and the other control-path
//   blocks: fetch FSM state encoding, instruction/address widths and the
//   sequential PC step helper.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 32;

   localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

   // 2-bit fetch FSM encoding
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      VALID = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   // Sequential successor of a PC; wraps modulo 2^32.
   function automatic logic [ADDR_W-1:0] next_seq_pc(input logic [ADDR_W-1:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// -----------------------------------------------------------------------------
// fetch_addr_check
//   Purely combinational legality check for a word access: the address must be
//   word aligned and lie in [BASE, LIMIT). Usable for instruction fetch and for
//   data-side segmentation checks alike.
//
//   Parameters : BASE  - lowest legal address
//                LIMIT - first illegal address (exclusive), must exceed BASE
//   Ports      : addr  - address under test
//                legal - 1 when the access is allowed
// -----------------------------------------------------------------------------
module fetch_addr_check
   import instr_fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE  = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] LIMIT = 32'h0001_0000
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              legal
);

   logic [ADDR_W-1:0] offset;

   // Rebasing to BASE turns the two-sided range test into one unsigned compare:
   // addresses below BASE wrap to huge offsets and fall out of range.
   assign offset = addr - BASE;
   assign legal  = (addr[1:0] == 2'b00) && (offset < (LIMIT - BASE));

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Single-buffer instruction fetch unit. Issues one read at a time to the
//   instruction memory, holds the returned word, and faults on illegal
//   addresses or bus errors.
//
//   Ports:
//     clk          - clock, all state on posedge
//     reset_n      - synchronous reset, ACTIVE HIGH despite the name
//     pc_inc       - consumer took the instruction, advance by one word
//     pc_load      - redirect to pc_target (wins over pc_inc)
//     pc_target    - redirect address
//     mem_ack      - read response this cycle
//     mem_err      - bus error, qualified by mem_ack
//     mem_rdata    - read data, qualified by mem_ack
//     mem_req      - read request, held until mem_ack
//     mem_addr     - read address (always pc)
//     instruction  - buffered instruction word
//     wait_instr   - instruction not yet valid (state FETCH)
//     instr_segv   - fetch fault (state FAULT)
//     pc           - address of the word held in instruction
// -----------------------------------------------------------------------------
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] INSTR_BASE  = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] INSTR_LIMIT = 32'h0001_0000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               pc_inc,
   input  logic               pc_load,
   input  logic [ADDR_W-1:0]  pc_target,
   input  logic               mem_ack,
   input  logic               mem_err,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [INSTR_W-1:0] instruction,
   output logic               wait_instr,
   output logic               instr_segv,
   output logic [ADDR_W-1:0]  pc
);

   fetch_state_e       state_q;
   logic [ADDR_W-1:0]  pc_q;
   logic [ADDR_W-1:0]  target_q;
   logic [INSTR_W-1:0] instr_q;
   logic               redir_q;

   logic               pc_legal;
   logic [ADDR_W-1:0]  pc_seq_d;
   logic [ADDR_W-1:0]  redir_pc_d;

   fetch_addr_check #(
      .BASE  (INSTR_BASE),
      .LIMIT (INSTR_LIMIT)
   ) u_addr_check (
      .addr  (pc_q),
      .legal (pc_legal)
   );

   assign pc_seq_d   = next_seq_pc(pc_q);
   // A redirect arriving in the same cycle as the ack is newer than any stored one.
   assign redir_pc_d = pc_load ? pc_target : target_q;

   always_ff @(posedge clk) begin
      if (reset_n) begin
         // Any outstanding read is abandoned; the memory side drops it too.
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         target_q <= RESET_PC;
         instr_q  <= '0;
         redir_q  <= 1'b0;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (!pc_legal) begin
                  // No request was ever issued for this pc, so no ack can be in flight.
                  state_q <= FAULT;
               end else if (mem_ack) begin
                  if (redir_q || pc_load) begin
                     // Response belongs to an abandoned address: drop data and any
                     // error with it, then fetch the redirect target.
                     pc_q    <= redir_pc_d;
                     redir_q <= 1'b0;
                  end else if (mem_err) begin
                     state_q <= FAULT;
                  end else begin
                     instr_q <= mem_rdata;
                     state_q <= VALID;
                  end
               end else if (pc_load) begin
                  // mem_addr must stay put until the ack, so park the target.
                  target_q <= pc_target;
                  redir_q  <= 1'b1;
               end
            end
            VALID: begin
               if (pc_load) begin
                  pc_q    <= pc_target;
                  state_q <= FETCH;
               end else if (pc_inc) begin
                  pc_q    <= pc_seq_d;
                  state_q <= FETCH;
               end
            end
            FAULT: begin
               if (pc_load) begin
                  pc_q    <= pc_target;
                  state_q <= FETCH;
               end
            end
            default: state_q <= FETCH;
         endcase
      end
   end

   // Request only for legal addresses; an illegal pc goes straight to FAULT.
   assign mem_req     = (state_q == FETCH) && pc_legal;
   assign mem_addr    = pc_q;
   assign instruction = instr_q;
   assign wait_instr  = (state_q == FETCH);
   assign instr_segv  = (state_q == FAULT);
   assign pc          = pc_q;

endmodule
